// File: rtl/pool_engine.sv
// pool_engine: buffered 2-D max/avg pooling over NUM_CHANNELS feature maps.
// Inputs are loaded by index, a pass fills the output buffer, and results are read back by index.
module pool_engine #(
  parameter int NUM_CHANNELS = 16,
  parameter int INPUT_DIM    = 26,
  parameter int KERNEL_DIM   = 2,
  parameter int STRIDE       = KERNEL_DIM,
  parameter int DATA_SIZE    = 16,
  parameter int AVG_SHIFT    = 2,
  parameter int ACC_SIZE     = DATA_SIZE + 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_write,
  input  logic [DATA_SIZE-1:0] in_write_data,
  input  logic [15:0]          in_write_ch,
  input  logic [15:0]          in_write_y,
  input  logic [15:0]          in_write_x,
  output logic                 in_write_err,
  input  logic [1:0]           mode,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic [15:0]          out_read_ch,
  input  logic [15:0]          out_read_y,
  input  logic [15:0]          out_read_x,
  output logic [DATA_SIZE-1:0] out_read_data
);

  localparam int OD        = (INPUT_DIM - KERNEL_DIM) / STRIDE + 1;
  localparam int IN_DEPTH  = NUM_CHANNELS * INPUT_DIM * INPUT_DIM;
  localparam int OUT_DEPTH = NUM_CHANNELS * OD * OD;
  localparam int IN_AW     = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int OUT_AW    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  localparam logic signed [DATA_SIZE-1:0] D_MAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
  localparam logic signed [DATA_SIZE-1:0] D_MIN = {1'b1, {(DATA_SIZE-1){1'b0}}};
  localparam logic signed [ACC_SIZE-1:0]  A_MAX = ACC_SIZE'(D_MAX);
  localparam logic signed [ACC_SIZE-1:0]  A_MIN = ACC_SIZE'(D_MIN);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACC, S_WRITE, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [DATA_SIZE-1:0] in_mem  [IN_DEPTH];
  logic [DATA_SIZE-1:0] out_mem [OUT_DEPTH];

  logic [15:0] ch, oy, ox, ky, kx;
  logic [1:0]  mode_q;

  logic signed [DATA_SIZE-1:0] rd_data;
  logic signed [ACC_SIZE-1:0]  acc, elem, avg_s;
  logic signed [DATA_SIZE-1:0] res_pre, result;

  logic              wr_ok, start_ok, last_k, last_win, rd_ok;
  logic [IN_AW-1:0]  in_waddr, in_raddr;
  logic [OUT_AW-1:0] out_waddr, out_raddr;

  assign wr_ok = in_write && !busy
              && 32'(in_write_ch) < NUM_CHANNELS
              && 32'(in_write_y) < INPUT_DIM
              && 32'(in_write_x) < INPUT_DIM;

  assign start_ok = start && !busy
                 && (state_q == S_IDLE || state_q == S_DONE);

  assign last_k = kx == 16'(KERNEL_DIM - 1)
               && ky == 16'(KERNEL_DIM - 1);

  assign last_win = ch == 16'(NUM_CHANNELS - 1)
                 && oy == 16'(OD - 1)
                 && ox == 16'(OD - 1);

  assign rd_ok = 32'(out_read_ch) < NUM_CHANNELS
              && 32'(out_read_y) < OD
              && 32'(out_read_x) < OD;

  assign in_waddr = IN_AW'((32'(in_write_ch) * INPUT_DIM
                   + 32'(in_write_y)) * INPUT_DIM
                   + 32'(in_write_x));

  assign in_raddr = IN_AW'((32'(ch) * INPUT_DIM
                   + 32'(oy) * STRIDE + 32'(ky)) * INPUT_DIM
                   + 32'(ox) * STRIDE + 32'(kx));

  assign out_waddr = OUT_AW'((32'(ch) * OD + 32'(oy)) * OD
                    + 32'(ox));

  assign out_raddr = OUT_AW'((32'(out_read_ch) * OD
                    + 32'(out_read_y)) * OD
                    + 32'(out_read_x));

  assign elem = ACC_SIZE'(rd_data);

  always_comb begin
    avg_s   = acc >>> AVG_SHIFT;
    res_pre = acc[DATA_SIZE-1:0];
    if (mode_q[0]) begin
      if (avg_s > A_MAX)      res_pre = D_MAX;
      else if (avg_s < A_MIN) res_pre = D_MIN;
      else                    res_pre = avg_s[DATA_SIZE-1:0];
    end
    result = (mode_q[1] && res_pre[DATA_SIZE-1]) ? '0 : res_pre;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_ADDR;
      S_DONE:  if (start_ok) state_d = S_ADDR;
      S_ADDR:  state_d = S_ACC;
      S_ACC:   state_d = last_k ? S_WRITE : S_ADDR;
      S_WRITE: state_d = last_win ? S_DONE : S_ADDR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Buffers carry no reset so they map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) in_mem[in_waddr] <= in_write_data;
    rd_data <= in_mem[in_raddr];
    if (state_q == S_WRITE) out_mem[out_waddr] <= result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      in_write_err  <= 1'b0;
      mode_q        <= 2'b00;
      out_read_data <= '0;
    end else begin
      in_write_err  <= in_write && !wr_ok;
      out_read_data <= rd_ok ? out_mem[out_raddr] : '0;
      if (start_ok) begin
        busy   <= 1'b1;
        done   <= 1'b0;
        mode_q <= mode;
      end else if (state_q == S_DONE && busy) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start_ok) begin
      ch <= '0; oy <= '0; ox <= '0;
      ky <= '0; kx <= '0;
    end else if (state_q == S_ACC) begin
      // Max seeds from element 0 so all-negative windows stay exact.
      if ((kx == '0 && ky == '0) || (!mode_q[0] && elem > acc))
        acc <= elem;
      else if (mode_q[0])
        acc <= acc + elem;
      if (last_k) begin
        kx <= '0; ky <= '0;
      end else if (kx == 16'(KERNEL_DIM - 1)) begin
        kx <= '0; ky <= ky + 16'd1;
      end else begin
        kx <= kx + 16'd1;
      end
    end else if (state_q == S_WRITE) begin
      if (ox == 16'(OD - 1)) begin
        ox <= '0;
        if (oy == 16'(OD - 1)) begin
          oy <= '0;
          ch <= ch + 16'd1;
        end else begin
          oy <= oy + 16'd1;
        end
      end else begin
        ox <= ox + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pool_engine.sv
// tb_pool_engine: randomized directed bench for pool_engine.
// Expected pool results come from a plain array model of the input maps.
module tb_pool_engine;

  localparam int C  = 2;
  localparam int IN = 8;
  localparam int K  = 3;
  localparam int S  = 2;
  localparam int DS = 16;
  localparam int SH = 1;
  localparam int OD = (IN - K) / S + 1;
  localparam int NCYC = C * OD * OD * (2 * K * K + 1) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_write;
  logic [DS-1:0] in_write_data;
  logic [15:0]   in_write_ch, in_write_y, in_write_x;
  logic          in_write_err;
  logic [1:0]    mode;
  logic          start;
  logic          busy, done;
  logic [15:0]   out_read_ch, out_read_y, out_read_x;
  logic [DS-1:0] out_read_data;

  int ncomp = 0;
  int nfail = 0;
  int mdl [C][IN][IN];

  always #5 clk = ~clk;

  pool_engine #(
    .NUM_CHANNELS(C), .INPUT_DIM(IN), .KERNEL_DIM(K),
    .STRIDE(S), .DATA_SIZE(DS), .AVG_SHIFT(SH),
    .ACC_SIZE(DS + 8)
  ) dut (
    .clk(clk), .rst(rst),
    .in_write(in_write), .in_write_data(in_write_data),
    .in_write_ch(in_write_ch), .in_write_y(in_write_y),
    .in_write_x(in_write_x), .in_write_err(in_write_err),
    .mode(mode), .start(start), .busy(busy), .done(done),
    .out_read_ch(out_read_ch), .out_read_y(out_read_y),
    .out_read_x(out_read_x), .out_read_data(out_read_data)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_out(int c, int y0, int x0, logic [1:0] m);
    longint s;
    int mx, v, r;
    s  = 0;
    mx = mdl[c][y0 * S][x0 * S];
    for (int ky = 0; ky < K; ky++)
      for (int kx = 0; kx < K; kx++) begin
        v = mdl[c][y0 * S + ky][x0 * S + kx];
        s += v;
        if (v > mx) mx = v;
      end
    if (m[0]) begin
      s = s >>> SH;
      if (s > 32767)       r = 32767;
      else if (s < -32768) r = -32768;
      else                 r = int'(s);
    end else begin
      r = mx;
    end
    if (m[1] && r < 0) r = 0;
    return r;
  endfunction

  task automatic wr(input int c, input int y, input int x,
                    input int d);
    in_write      = 1'b1;
    in_write_ch   = 16'(c);
    in_write_y    = 16'(y);
    in_write_x    = 16'(x);
    in_write_data = DS'(d);
    @(negedge clk);
    in_write = 1'b0;
  endtask

  task automatic rd(input int c, input int y, input int x);
    out_read_ch = 16'(c);
    out_read_y  = 16'(y);
    out_read_x  = 16'(x);
    @(negedge clk);
  endtask

  task automatic fill(input int kind);
    int v, errs;
    errs = 0;
    for (int c = 0; c < C; c++)
      for (int y = 0; y < IN; y++)
        for (int x = 0; x < IN; x++) begin
          case (kind)
            1:       v = 32767;
            2:       v = -32768;
            3:       v = -int'($urandom_range(1, 32768));
            default: v = int'($urandom_range(0, 65535)) - 32768;
          endcase
          wr(c, y, x, v);
          mdl[c][y][x] = v;
          errs += int'(in_write_err);
        end
    chk("fill_err", errs, 0);
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 4 * NCYC) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_outputs(input logic [1:0] m, input string tag);
    for (int c = 0; c < C; c++)
      for (int y = 0; y < OD; y++)
        for (int x = 0; x < OD; x++) begin
          rd(c, y, x);
          chk(tag, 32'($signed(out_read_data)), ref_out(c, y, x, m));
        end
  endtask

  task automatic run(input logic [1:0] m, input bit wr_also,
                     input int wd, input string tag);
    int n;
    mode  = m;
    start = 1'b1;
    if (wr_also) begin
      in_write      = 1'b1;
      in_write_ch   = 16'(C - 1);
      in_write_y    = 16'd0;
      in_write_x    = 16'd0;
      in_write_data = DS'(wd);
      mdl[C-1][0][0] = wd;
    end
    @(negedge clk);
    start    = 1'b0;
    in_write = 1'b0;
    mode     = ~m;
    chk({tag, "_busy"}, int'(busy), 1);
    chk({tag, "_done_clr"}, int'(done), 0);
    wait_done(0, n);
    chk({tag, "_cycles"}, n, NCYC);
    chk({tag, "_busy_end"}, int'(busy), 0);
    check_outputs(m, tag);
  endtask

  initial begin
    int n;
    rst = 1'b1; in_write = 1'b0; start = 1'b0; mode = 2'b00;
    in_write_data = '0;
    in_write_ch = '0; in_write_y = '0; in_write_x = '0;
    out_read_ch = '0; out_read_y = '0; out_read_x = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(in_write_err), 0);
    chk("rst_rdata", int'(out_read_data), 0);
    rst = 1'b0;
    @(negedge clk);

    fill(0);
    run(2'b00, 1'b0, 0, "max");
    run(2'b01, 1'b0, 0, "avg");
    run(2'b10, 1'b0, 0, "max_relu");
    run(2'b11, 1'b0, 0, "avg_relu");

    fill(3);
    run(2'b00, 1'b0, 0, "neg_max");
    run(2'b11, 1'b0, 0, "neg_avg_relu");

    fill(1);
    run(2'b01, 1'b0, 0, "sat_hi");
    fill(2);
    run(2'b01, 1'b0, 0, "sat_lo");

    fill(0);
    mode = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr(0, 0, 0, 123);
    chk("busy_wr_err", int'(in_write_err), 1);
    @(negedge clk);
    chk("err_single_pulse", int'(in_write_err), 0);
    wait_done(3, n);
    chk("busy_cycles", n, NCYC);
    check_outputs(2'b00, "busy_out");

    wr(0, 0, IN, 5);
    chk("err_x_range", int'(in_write_err), 1);
    wr(0, IN, 0, 5);
    chk("err_y_range", int'(in_write_err), 1);
    wr(C, 0, 0, 5);
    chk("err_ch_range", int'(in_write_err), 1);
    @(negedge clk);
    chk("err_clear", int'(in_write_err), 0);
    rd(C, 0, 0);
    chk("rd_ch_range", int'(out_read_data), 0);
    rd(0, OD, 0);
    chk("rd_y_range", int'(out_read_data), 0);

    run(2'b01, 1'b1, int'($urandom_range(0, 65535)) - 32768, "start_wr");

    mode = 2'b01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    run(2'b00, 1'b0, 0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/pool_engine.md
Name: pool_engine

Overview:
Parametrised 2-D pooling unit, successor to the max-pool layer block. Holds per-channel input activations in an internal buffer loaded by index. On start, scans every channel/window with configurable kernel and stride and writes one result per window into an internal output buffer. Results are read back by index. Run-time mode selects max or average pooling, each with optional ReLU. Signed fixed-point data replaces real-valued data.

Parameters:
NUM_CHANNELS, 16, number of independent feature maps
INPUT_DIM, 26, input map height = width
KERNEL_DIM, 2, pooling window side
STRIDE, KERNEL_DIM, window step in x and y
DATA_SIZE, 16, signed two's-complement element width
AVG_SHIFT, 2, arithmetic right shift applied to the window sum in average mode
ACC_SIZE, DATA_SIZE+8, accumulator width; must hold KERNEL_DIM^2 x max magnitude
OUTPUT_DIM, (INPUT_DIM-KERNEL_DIM)/STRIDE+1, derived output side; not overridden

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_write  in  1  write in_write_data to input buffer this cycle
in_write_data  in  DATA_SIZE  input element
in_write_ch / in_write_y / in_write_x  in  16 each  input write index
in_write_err  out  1  one-cycle pulse: write rejected (busy or index out of range)
mode  in  2  00 max, 01 avg, 10 max+ReLU, 11 avg+ReLU; sampled on accepted start
start  in  1  begin a pooling pass
busy  out  1  high from accepted start until pass complete
done  out  1  sticky; set at pass completion, cleared by next accepted start or rst
out_read_ch / out_read_y / out_read_x  in  16 each  output read index
out_read_data  out  DATA_SIZE  registered read data, 1-cycle latency

Behaviour:
- Reset: busy=0, done=0, in_write_err=0, out_read_data=0, FSM=IDLE, latched mode=00. Buffer contents are not cleared.
- Input write: accepted when in_write=1, busy=0, and ch<NUM_CHANNELS, y<INPUT_DIM, x<INPUT_DIM. Otherwise it is dropped and in_write_err pulses the next cycle.
- Output read: out_read_data is updated every cycle from the index presented on the previous edge. An out-of-range index returns 0. A read while busy returns current buffer contents, which may be stale.
- Start: accepted only in IDLE or DONE. Start while busy is ignored with no effect.
- FSM states:
  - IDLE: wait for start.
  - ADDR: issue input address for kernel element k (ky=k/KERNEL_DIM, kx=k%KERNEL_DIM; y=oy*STRIDE+ky, x=ox*STRIDE+kx).
  - ACC: combine the returned element.
  - WRITE: store the result and advance the window.
  - DONE: busy=0, done=1; start goes to ADDR.
- Cycle cost: ADDR/ACC alternate for k=0..K*K-1, then 1 WRITE cycle. Each window costs 2*K*K+1 cycles.
- Window order: ox fastest, then oy, then ch. After WRITE of (NUM_CHANNELS-1, OD-1, OD-1), go to DONE.
- Latency: start accepted at edge 0; busy=1 after edge 0; done=1 and busy=0 after edge NUM_CHANNELS*OD^2*(2*K*K+1)+1.
- Max mode: accumulator loads element k=0 (not zero), then takes the signed max. All-negative windows therefore yield the true max.
- Avg mode:
  - Sign-extended sum in ACC_SIZE; result = sum >>> AVG_SHIFT (floor).
  - Saturate to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
- ReLU modes: a negative final result is written as 0.
- Trailing input rows/cols not covered by a full window are never read (floor in OUTPUT_DIM).
- rst mid-pass: returns to IDLE next edge, busy=0, done=0. A partially written output buffer keeps its contents.
- Simultaneous start and in_write in IDLE: the write is accepted, the pass starts, and the pass reads the new value.

Test Plan:
- C=1,IN=4,K=2,S=2, mode 00, input row-major -8..7 -> outputs [-3,-1,5,7]; done high exactly 37 cycles after start edge.
- Same input, mode 01, AVG_SHIFT=2 -> outputs [-6>>>... floor((-8-7-4-3)/4)=-6, -4, 2, 4]. Mode 11 -> [0,0,2,4]. Mode 10 -> [0,0,5,7].
- IN=5,K=3,S=1, mode 00, input value = y*5+x -> OD=3, output(y,x)=(y+2)*5+x+2, e.g. (0,0)=12, (2,2)=24.
- DATA_SIZE=16, K=2, all inputs 32767, AVG_SHIFT=0 -> every output saturates to 32767; with all -32768 -> -32768.
- Start during busy, in_write during busy, write index x=IN -> pass length unchanged; in_write_err pulses once per rejected write; buffer unchanged.
- rst asserted mid-pass, then start with mode 00 -> busy/done clear on next edge; second pass completes with correct full results and correct cycle count.
